fifo_rd_drain: RTL
==================

// Module: fifo_rd_drain
// PURPOSE
// - Read-side consumer for the dual-clock pointer FIFO; runs entirely in the read clock domain.
// - Issues pop strobes while the FIFO is non-empty and absorbs the fixed FIFO read latency.
// - Presents popped words on a valid/ready stream. A credit scheme guarantees no word is dropped under backpressure.
// PARAMETERS
// - DATA_WIDTH  default 8  : width of fifo_rdata and m_data.
// - RD_LATENCY  default 1  : cycles from a fifo_rd pulse to fifo_rdata holding that word; legal range 1..4.
// - BUF_DEPTH   derived     : RD_LATENCY+2, the skid-buffer entry count. Localparam, not overridable.
// PORTS
// - aclk        in   1           read-domain clock, rising edge.
// - aresetn     in   1           asynchronous active-low reset.
// - drain_en    in   1           level; 1 = run, 0 = stop popping and finish in-flight words.
// - fifo_uflow  in   1           FIFO empty flag; 1 = no word available this cycle.
// - fifo_rd     out  1           pop strobe, one word per cycle it is high.
// - fifo_rdata  in   DATA_WIDTH  FIFO read data, valid RD_LATENCY cycles after the pop.
// - m_valid     out  1           output word available.
// - m_data      out  DATA_WIDTH  output word; stable while m_valid && !m_ready.
// - m_ready     in   1           downstream accept; a transfer occurs when m_valid && m_ready.
// - busy        out  1           state != IDLE.
// BEHAVIOUR
// - Reset (async assert): state=IDLE, fifo_rd=0, m_valid=0, m_data=0, busy=0.
//   Reset also clears in-flight tags, buffer pointers and occupancy; in-flight words are discarded.
// - Reset release is synchronous to aclk. No pop is issued in the first cycle after release.
// - FSM states: IDLE, RUN, STOP.
//   IDLE -> RUN  when drain_en=1.
//   RUN  -> STOP when drain_en=0.
//   STOP -> RUN  when drain_en=1.
//   STOP -> IDLE when inflight==0 && occ==0.
// - fifo_rd is combinational: (state==RUN) && !fifo_uflow && (inflight+occ < BUF_DEPTH).
// - No pops are issued in IDLE or STOP.
// - In-flight tracking: an RD_LATENCY-deep valid shift register.
//   When its last stage is 1, fifo_rdata is written to buf[wr_idx] on that edge.
//   inflight = popcount of the shift register.
// - Skid buffer: circular array of BUF_DEPTH entries.
//   wr_idx and rd_idx wrap from BUF_DEPTH-1 to 0 explicitly; the depth need not be a power of two.
//   occ has width $clog2(BUF_DEPTH+1).
// - m_valid = (occ!=0); m_data = buf[rd_idx]. No added latency once a word is in the buffer.
// - Simultaneous capture and accept in one cycle: occ is unchanged and both indices advance.
// - Credit rule: inflight+occ never exceeds BUF_DEPTH.
//   Overrun is impossible by construction; the bench asserts it.
// - Minimum latency: pop at cycle N -> m_valid at cycle N+RD_LATENCY+1.
// - Full-rate throughput: with m_ready=1 and the FIFO never empty, fifo_rd stays high every cycle.
// - m_ready is ignored when m_valid=0. fifo_rdata is ignored when the last tag stage is 0.
// CONFIGURATION
// - DRAIN_CNT_EN defined: adds output drain_cnt [31:0].
//   Reset value 0; increments on each m_valid&&m_ready transfer; saturates at 32'hFFFF_FFFF.
//   Not cleared by a drain_en toggle.
// - DRAIN_CNT_EN undefined: the drain_cnt port and its logic are absent; all other behaviour is identical.
// TESTING
// - T1 Reset: reset while in RUN with 2 words in flight.
//   -> fifo_rd=0, m_valid=0, busy=0 in the same cycle; no stale word appears after release.
// - T2 Streaming: RD_LATENCY=1, m_ready=1, 16 words 0x00..0x0F available.
//   -> fifo_rd high 16 consecutive cycles; m_data 0x00..0x0F in order, first word 2 cycles after the first pop.
// - T3 Backpressure: m_ready=0 with FIFO non-empty.
//   -> exactly BUF_DEPTH=3 pops, then fifo_rd=0.
//   Release m_ready -> all 3 words delivered in order, no loss or duplication.
// - T4 Empty: fifo_uflow toggles 1/0 every cycle.
//   -> fifo_rd only in cycles with fifo_uflow=0; output sequence is gap-tolerant and in order.
// - T5 Stop: drop drain_en with 2 words in flight and 1 buffered.
//   -> no further pops; 3 words drained; busy falls the cycle after the last transfer (STOP->IDLE).
// - T6 DRAIN_CNT_EN: 10 transfers -> drain_cnt=10.
//   Force the counter to 32'hFFFF_FFFE, do 3 transfers -> 32'hFFFF_FFFF.

Source files
------------

// File: rtl/fifo_rd_drain.sv
// ---------------------------------------------------------------------------
// fifo_rd_drain
//
// Read-side consumer for the dual-clock pointer FIFO. Everything here runs in
// the read clock domain (aclk).
//
// The block pops words from the FIFO while it is non-empty and waits out the
// fixed FIFO read latency. It then presents the words on a valid/ready
// output stream. Every pop reserves a slot in a small skid buffer before it
// is issued, so a word can never arrive to find the buffer full. Because of
// this, backpressure on m_ready never loses data.
//
// Parameters
//   DATA_WIDTH : width of fifo_rdata / m_data.
//   RD_LATENCY : cycles from a fifo_rd pulse until fifo_rdata holds that word
//                (legal range 1..4).
//   BUF_DEPTH  : derived localparam, RD_LATENCY+2 skid-buffer entries.
//
// Ports
//   aclk        in   read-domain clock, rising edge
//   aresetn     in   asynchronous active-low reset
//   drain_en    in   level: 1 = run, 0 = stop popping and finish in-flight
//   fifo_uflow  in   FIFO empty flag (1 = nothing to pop this cycle)
//   fifo_rd     out  pop strobe, one word per high cycle (combinational)
//   fifo_rdata  in   FIFO read data, valid RD_LATENCY cycles after the pop
//   m_valid     out  output word available
//   m_data      out  output word
//   m_ready     in   downstream accept
//   busy        out  FSM is not in IDLE
//   drain_cnt   out  [31:0] saturating transfer count (only with DRAIN_CNT_EN)
//
// Optional feature: define DRAIN_CNT_EN to add the drain_cnt output.
//
// Output handshake: a word transfers on every rising aclk edge where
// m_valid && m_ready. While m_valid is high and m_ready is low, m_data holds
// its value. m_valid never depends on m_ready, and m_ready is ignored while
// m_valid is low.
// ---------------------------------------------------------------------------
module fifo_rd_drain #(
  parameter int DATA_WIDTH = 8,
  parameter int RD_LATENCY = 1
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  drain_en,
  input  logic                  fifo_uflow,
  output logic                  fifo_rd,
  input  logic [DATA_WIDTH-1:0] fifo_rdata,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  input  logic                  m_ready,
  output logic                  busy
`ifdef DRAIN_CNT_EN
  ,
  output logic [31:0]           drain_cnt
`endif
);

  localparam int BUF_DEPTH = RD_LATENCY + 2;
  localparam int OCC_W     = $clog2(BUF_DEPTH + 1);
  localparam int IDX_W     = $clog2(BUF_DEPTH);

  localparam logic [OCC_W:0]   DEPTH_SUM = (OCC_W + 1)'(BUF_DEPTH);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(BUF_DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  // One tag bit per outstanding read cycle. The last stage marks the cycle
  // in which fifo_rdata holds a word that this block actually popped.
  logic [RD_LATENCY-1:0] tag;
  logic [OCC_W-1:0]      inflight;
  logic [OCC_W-1:0]      occ;
  logic [OCC_W:0]        credit_sum;
  logic                  credit_ok;

  logic [DATA_WIDTH-1:0] buf_mem [BUF_DEPTH];
  logic [IDX_W-1:0]      wr_idx;
  logic [IDX_W-1:0]      rd_idx;

  logic capture;
  logic accept;

  // -------------------------------------------------------------------------
  // Credit accounting: a pop is only allowed when the words already in
  // flight plus the words sitting in the buffer leave at least one free slot.
  // -------------------------------------------------------------------------
  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LATENCY; i++) begin
      inflight = inflight + OCC_W'(tag[i]);
    end
  end

  assign credit_sum = {1'b0, inflight} + {1'b0, occ};
  assign credit_ok  = (credit_sum < DEPTH_SUM);

  assign fifo_rd = (state == RUN) && !fifo_uflow && credit_ok;

  assign capture = tag[RD_LATENCY-1];
  assign m_valid = (occ != '0);
  assign m_data  = buf_mem[rd_idx];
  assign accept  = m_valid && m_ready;

  assign busy = (state != IDLE);

  // -------------------------------------------------------------------------
  // FSM
  // -------------------------------------------------------------------------
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (drain_en) state_nxt = RUN;
      end
      RUN: begin
        if (!drain_en) state_nxt = STOP;
      end
      STOP: begin
        // Re-enabling takes priority over finishing the drain.
        if (drain_en) begin
          state_nxt = RUN;
        end else if ((inflight == '0) && (occ == '0)) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // In-flight tag pipeline
  // -------------------------------------------------------------------------
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      tag <= '0;
    end else begin
      tag[0] <= fifo_rd;
      for (int i = 1; i < RD_LATENCY; i++) begin
        tag[i] <= tag[i-1];
      end
    end
  end

  // -------------------------------------------------------------------------
  // Skid buffer. The depth is generally not a power of two, so both indices
  // wrap explicitly. The contents are cleared on reset so that m_data reads
  // zero out of reset.
  // -------------------------------------------------------------------------
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int i = 0; i < BUF_DEPTH; i++) begin
        buf_mem[i] <= '0;
      end
    end else if (capture) begin
      buf_mem[wr_idx] <= fifo_rdata;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_idx <= '0;
    end else if (capture) begin
      wr_idx <= (wr_idx == LAST_IDX) ? '0 : wr_idx + IDX_W'(1);
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rd_idx <= '0;
    end else if (accept) begin
      rd_idx <= (rd_idx == LAST_IDX) ? '0 : rd_idx + IDX_W'(1);
    end
  end

  // If a capture and an accept happen in the same cycle, occupancy stays the
  // same while both indices advance.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      occ <= '0;
    end else begin
      case ({capture, accept})
        2'b10:   occ <= occ + OCC_W'(1);
        2'b01:   occ <= occ - OCC_W'(1);
        default: occ <= occ;
      endcase
    end
  end

`ifdef DRAIN_CNT_EN
  // -------------------------------------------------------------------------
  // Saturating transfer counter. It is cleared only by reset and keeps
  // counting across drain_en toggles.
  // -------------------------------------------------------------------------
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      drain_cnt <= '0;
    end else if (accept && (drain_cnt != 32'hFFFF_FFFF)) begin
      drain_cnt <= drain_cnt + 32'd1;
    end
  end
`endif

endmodule
